// File: rtl/mm_bus_pkg.sv
// Shared types and constants for the memory-mapped bus arbiter.
// Holds default bus widths, the arbiter state encoding and owner encodings.
package mm_bus_pkg;

    localparam int MM_ADDR_WIDTH_DEF = 8;
    localparam int MM_DATA_WIDTH_DEF = 16;
    localparam int LOCK_CNT_WIDTH    = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_ACK    = 2'b10
    } arb_state_e;

    typedef enum logic {
        OWNER_M0 = 1'b0,
        OWNER_M1 = 1'b1
    } owner_e;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_M0   = 2'b01;
    localparam logic [1:0] GRANT_M1   = 2'b10;

    function automatic logic [1:0] owner_onehot(input owner_e owner);
        return (owner == OWNER_M1) ? GRANT_M1 : GRANT_M0;
    endfunction

endpackage

// File: rtl/mm_arb_pick.sv
// Combinational 2-way selector: round-robin on ties, or fixed M0 priority
// when MM_ARB_FIXED_PRIO_EN is defined. A held lock restricts the pick to last_owner.
module mm_arb_pick
    import mm_bus_pkg::*;
(
    input  logic [1:0] req_i,
    input  owner_e     last_owner_i,
    input  logic       lock_active_i,
    output logic [1:0] pick_o
);

    // NOTE: pick_o gets a default before any branch so no path leaves it unassigned (no latch).
    always_comb begin
        pick_o = GRANT_NONE;
        if (lock_active_i) begin
            pick_o = req_i & owner_onehot(last_owner_i);
        end else if (req_i == 2'b11) begin
`ifdef MM_ARB_FIXED_PRIO_EN
            pick_o = GRANT_M0;
`else
            pick_o = (last_owner_i == OWNER_M0) ? GRANT_M1 : GRANT_M0;
`endif
        end else begin
            pick_o = req_i;
        end
    end

endmodule

// File: rtl/mm_bus_arbiter.sv
// Two-master arbiter for the shared memory-mapped slave bus: IDLE -> ACCESS -> ACK,
// one write strobe per write, optional bus lock. Tie policy set by MM_ARB_FIXED_PRIO_EN.
module mm_bus_arbiter
    import mm_bus_pkg::*;
#(
    parameter int MM_ADDR_WIDTH = MM_ADDR_WIDTH_DEF,
    parameter int MM_DATA_WIDTH = MM_DATA_WIDTH_DEF,
    parameter int LOCK_MAX      = 16
) (
    input  logic                     clk_sys_i,
    input  logic                     rst_n_i,

    input  logic                     m0_req_i,
    input  logic                     m0_lock_i,
    input  logic [MM_ADDR_WIDTH-1:0] m0_addr_i,
    input  logic [MM_DATA_WIDTH-1:0] m0_wdata_i,
    input  logic                     m0_we_i,
    output logic [MM_DATA_WIDTH-1:0] m0_rdata_o,
    output logic                     m0_ack_o,

    input  logic                     m1_req_i,
    input  logic                     m1_lock_i,
    input  logic [MM_ADDR_WIDTH-1:0] m1_addr_i,
    input  logic [MM_DATA_WIDTH-1:0] m1_wdata_i,
    input  logic                     m1_we_i,
    output logic [MM_DATA_WIDTH-1:0] m1_rdata_o,
    output logic                     m1_ack_o,

    output logic [MM_ADDR_WIDTH-1:0] mm_m_addr_o,
    output logic [MM_DATA_WIDTH-1:0] mm_m_wdata_o,
    output logic                     mm_m_we_o,
    input  logic [MM_DATA_WIDTH-1:0] mm_m_rdata_i,
    output logic [1:0]               grant_o
);

    localparam logic [LOCK_CNT_WIDTH-1:0] LOCK_LAST = LOCK_CNT_WIDTH'(LOCK_MAX - 1);

    arb_state_e                state_q, state_d;
    owner_e                    owner_q, owner_d;
    owner_e                    last_owner_q, last_owner_d;
    logic                      lock_active_q, lock_active_d;
    logic [LOCK_CNT_WIDTH-1:0] lock_cnt_q, lock_cnt_d;
    logic [1:0]                grant_q, grant_d;
    logic [MM_ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [MM_DATA_WIDTH-1:0]  wdata_q, wdata_d;
    logic                      we_q, we_d;
    logic [MM_DATA_WIDTH-1:0]  m0_rdata_q, m0_rdata_d;
    logic [MM_DATA_WIDTH-1:0]  m1_rdata_q, m1_rdata_d;
    logic                      m0_ack_q, m0_ack_d;
    logic                      m1_ack_q, m1_ack_d;

    logic       last_lock_in;
    logic       owner_lock_in;
    logic       lock_eff;
    logic [1:0] pick;

    assign last_lock_in  = (last_owner_q == OWNER_M1) ? m1_lock_i : m0_lock_i;
    assign owner_lock_in = (owner_q == OWNER_M1) ? m1_lock_i : m0_lock_i;
    // The lock holder releases immediately in IDLE by dropping lock_i.
    assign lock_eff      = lock_active_q & last_lock_in;

    mm_arb_pick u_pick (
        .req_i         ({m1_req_i, m0_req_i}),
        .last_owner_i  (last_owner_q),
        .lock_active_i (lock_eff),
        .pick_o        (pick)
    );

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        last_owner_d  = last_owner_q;
        lock_active_d = lock_active_q;
        lock_cnt_d    = lock_cnt_q;
        grant_d       = grant_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        we_d          = 1'b0;
        m0_rdata_d    = m0_rdata_q;
        m1_rdata_d    = m1_rdata_q;
        m0_ack_d      = 1'b0;
        m1_ack_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (lock_active_q && !last_lock_in) begin
                    lock_active_d = 1'b0;
                    lock_cnt_d    = '0;
                end
                if (pick != GRANT_NONE) begin
                    owner_d = pick[1] ? OWNER_M1 : OWNER_M0;
                    grant_d = pick;
                    addr_d  = pick[1] ? m1_addr_i  : m0_addr_i;
                    wdata_d = pick[1] ? m1_wdata_i : m0_wdata_i;
                    we_d    = pick[1] ? m1_we_i    : m0_we_i;
                    state_d = ST_ACCESS;
                end
            end

            ST_ACCESS: begin
                if (!we_q) begin
                    if (owner_q == OWNER_M1) m1_rdata_d = mm_m_rdata_i;
                    else                     m0_rdata_d = mm_m_rdata_i;
                end
                if (owner_q == OWNER_M1) m1_ack_d = 1'b1;
                else                     m0_ack_d = 1'b1;
                state_d = ST_ACK;
            end

            ST_ACK: begin
                last_owner_d = owner_q;
                grant_d      = GRANT_NONE;
                // Reaching the cap forces a release so the other master gets a turn.
                if (owner_lock_in && (lock_cnt_q < LOCK_LAST)) begin
                    lock_active_d = 1'b1;
                    lock_cnt_d    = lock_cnt_q + LOCK_CNT_WIDTH'(1);
                end else begin
                    lock_active_d = 1'b0;
                    lock_cnt_d    = '0;
                end
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
                grant_d = GRANT_NONE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_sys_i) begin
        if (!rst_n_i) begin
            state_q       <= ST_IDLE;
            owner_q       <= OWNER_M0;
            last_owner_q  <= OWNER_M1;
            lock_active_q <= 1'b0;
            lock_cnt_q    <= '0;
            grant_q       <= GRANT_NONE;
            addr_q        <= '0;
            wdata_q       <= '0;
            we_q          <= 1'b0;
            m0_rdata_q    <= '0;
            m1_rdata_q    <= '0;
            m0_ack_q      <= 1'b0;
            m1_ack_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            last_owner_q  <= last_owner_d;
            lock_active_q <= lock_active_d;
            lock_cnt_q    <= lock_cnt_d;
            grant_q       <= grant_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            we_q          <= we_d;
            m0_rdata_q    <= m0_rdata_d;
            m1_rdata_q    <= m1_rdata_d;
            m0_ack_q      <= m0_ack_d;
            m1_ack_q      <= m1_ack_d;
        end
    end

    assign mm_m_addr_o  = addr_q;
    assign mm_m_wdata_o = wdata_q;
    assign mm_m_we_o    = we_q;
    assign grant_o      = grant_q;
    assign m0_rdata_o   = m0_rdata_q;
    assign m1_rdata_o   = m1_rdata_q;
    assign m0_ack_o     = m0_ack_q;
    assign m1_ack_o     = m1_ack_q;

endmodule
